// File: rtl/keypad_scanner.sv
// keypad_scanner: 4x4 matrix keypad scanner/debouncer with valid/ready key delivery (optional KEYPAD_AUTOREPEAT_EN)
//   clk, rst (async, active-high), scan_clk (divided scan clock), row_n[3:0] (async, active-low)
//   col_n[3:0] (one-hot low column drive), key_code[3:0]/key_valid/key_ready handshake, key_pressed level
module keypad_scanner #(
  parameter int DEBOUNCE_SCANS = 4,
  parameter int REPEAT_SCANS   = 64
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       scan_clk,
  input  logic [3:0] row_n,
  output logic [3:0] col_n,
  output logic [3:0] key_code,
  output logic       key_valid,
  input  logic       key_ready,
  output logic       key_pressed
);
  localparam int MAXS = DEBOUNCE_SCANS > REPEAT_SCANS ? DEBOUNCE_SCANS : REPEAT_SCANS;
  localparam int CW = $clog2(MAXS + 1);
  typedef enum logic [1:0] {SCAN, PEND, HELD} state_t;
  typedef enum logic [1:0] {R_NONE, R_SINGLE, R_MULTI} res_t;
  logic [3:0] row_s1_q, row_s2_q;
  logic       scan_clk_q;
  logic [1:0] col_q, col_d;
  logic [1:0] acc_n_q, acc_n_d;
  logic [3:0] acc_code_q, acc_code_d;
  res_t       prev_kind_q, prev_kind_d;
  logic [3:0] prev_code_q, prev_code_d;
  logic [CW-1:0] db_q, db_d, db_new;
  state_t     state_q, state_d;
  logic [3:0] key_code_q, key_code_d;
  logic       key_valid_q, key_valid_d;
  logic       key_pressed_q, key_pressed_d;
  logic       scan_step, full, same, press_ok, rel_ok, hs;
  logic [3:0] low, code_now;
  logic [2:0] n_low, sum;
  logic [1:0] row_idx, tot;
  res_t       kind;
`ifdef KEYPAD_AUTOREPEAT_EN
  localparam int RW = $clog2(REPEAT_SCANS + 1);
  logic [RW-1:0] rep_q, rep_d;
`endif
  assign col_n = ~(4'b0001 << col_q);
  assign key_code = key_code_q;
  assign key_valid = key_valid_q;
  assign key_pressed = key_pressed_q;
  always_comb begin
    scan_step = scan_clk & ~scan_clk_q;
    low = ~row_s2_q;
    n_low = {2'b0, low[0]} + {2'b0, low[1]} + {2'b0, low[2]} + {2'b0, low[3]};
    row_idx = low[0] ? 2'd0 : low[1] ? 2'd1 : low[2] ? 2'd2 : 2'd3;
    // Running count of low rows this scan (saturates at 2 = "more than one"), restarted at column 0
    sum = {1'b0, col_q == 2'd0 ? 2'd0 : acc_n_q} + n_low;
    tot = sum >= 3'd2 ? 2'd2 : sum[1:0];
    code_now = n_low == 3'd1 ? {row_idx, col_q} : acc_code_q;
    full = scan_step && col_q == 2'd3;
    kind = tot == 2'd0 ? R_NONE : tot == 2'd1 ? R_SINGLE : R_MULTI;
    same = kind != R_MULTI && kind == prev_kind_q && (kind == R_NONE || code_now == prev_code_q);
    db_new = !same ? CW'(1) : db_q == CW'(MAXS) ? db_q : db_q + 1'b1;
    press_ok = full && kind == R_SINGLE && db_new >= CW'(DEBOUNCE_SCANS);
    rel_ok = full && kind == R_NONE && db_new >= CW'(DEBOUNCE_SCANS);
    hs = key_valid_q & key_ready;
    col_d = scan_step ? col_q + 2'd1 : col_q;
    acc_n_d = scan_step ? tot : acc_n_q;
    acc_code_d = scan_step ? code_now : acc_code_q;
    prev_kind_d = full ? kind : prev_kind_q;
    prev_code_d = full ? code_now : prev_code_q;
    db_d = full ? db_new : db_q;
    state_d = state_q;
    key_code_d = key_code_q;
    key_valid_d = key_valid_q;
    key_pressed_d = key_pressed_q;
`ifdef KEYPAD_AUTOREPEAT_EN
    rep_d = '0;
`endif
    case (state_q)
      SCAN: if (press_ok) begin
        state_d = PEND;
        key_code_d = code_now;
        key_valid_d = 1'b1;
        key_pressed_d = 1'b1;
      end
      PEND: begin
        if (rel_ok) key_pressed_d = 1'b0;
        if (hs) begin
          key_valid_d = 1'b0;
          state_d = (rel_ok || !key_pressed_q) ? SCAN : HELD;
        end
      end
      HELD: if (rel_ok) begin
        key_pressed_d = 1'b0;
        state_d = SCAN;
      end
`ifdef KEYPAD_AUTOREPEAT_EN
      else if (full) begin
        rep_d = (kind == R_SINGLE && code_now == key_code_q) ? rep_q + 1'b1 : '0;
        if (rep_d == RW'(REPEAT_SCANS)) begin
          rep_d = '0;
          key_valid_d = 1'b1;
          state_d = PEND;
        end
      end else rep_d = rep_q;
`endif
      default: state_d = SCAN;
    endcase
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      row_s1_q <= 4'hf;
      row_s2_q <= 4'hf;
      scan_clk_q <= 1'b0;
      col_q <= '0;
      acc_n_q <= '0;
      acc_code_q <= '0;
      prev_kind_q <= R_NONE;
      prev_code_q <= '0;
      db_q <= '0;
      state_q <= SCAN;
      key_code_q <= '0;
      key_valid_q <= 1'b0;
      key_pressed_q <= 1'b0;
`ifdef KEYPAD_AUTOREPEAT_EN
      rep_q <= '0;
`endif
    end else begin
      row_s1_q <= row_n;
      row_s2_q <= row_s1_q;
      scan_clk_q <= scan_clk;
      col_q <= col_d;
      acc_n_q <= acc_n_d;
      acc_code_q <= acc_code_d;
      prev_kind_q <= prev_kind_d;
      prev_code_q <= prev_code_d;
      db_q <= db_d;
      state_q <= state_d;
      key_code_q <= key_code_d;
      key_valid_q <= key_valid_d;
      key_pressed_q <= key_pressed_d;
`ifdef KEYPAD_AUTOREPEAT_EN
      rep_q <= rep_d;
`endif
    end
  end
endmodule

// File: tb/tb_keypad_scanner.sv
// tb_keypad_scanner: directed bench for keypad_scanner with a behavioural 4x4 key matrix
module tb_keypad_scanner;
  logic clk = 0, rst = 1, key_ready = 0;
  logic [2:0] div = 0;
  logic scan_clk;
  logic [3:0] row_n, col_n, key_code;
  logic key_valid, key_pressed;
  logic [15:0] keys = 0;
  int n_vec = 0, n_err = 0;
  int hs_cnt = 0, v_cyc = 0;
  logic [3:0] last_code = 0;
  int h0, c0;
  keypad_scanner #(.DEBOUNCE_SCANS(4), .REPEAT_SCANS(8)) dut (
    .clk(clk), .rst(rst), .scan_clk(scan_clk), .row_n(row_n), .col_n(col_n),
    .key_code(key_code), .key_valid(key_valid), .key_ready(key_ready), .key_pressed(key_pressed)
  );
  always #5 clk = ~clk;
  always @(posedge clk) div <= div + 3'd1;
  assign scan_clk = div[2];
  always_comb begin
    row_n = 4'hf;
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++)
        if (keys[r*4+c] && !col_n[c]) row_n[r] = 1'b0;
  end
  always @(posedge clk) begin
    if (!rst && key_valid && key_ready) begin
      hs_cnt <= hs_cnt + 1;
      last_code <= key_code;
    end
    if (!rst && key_valid) v_cyc <= v_cyc + 1;
  end
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask
  task automatic scans(input int n);
    repeat (n * 32) @(negedge clk);
  endtask
  initial begin
    repeat (3) @(negedge clk);
    chk("rst_col", col_n, 4'he);
    chk("rst_valid", key_valid, 0);
    chk("rst_pressed", key_pressed, 0);
    chk("rst_code", key_code, 0);
    rst = 0;
    key_ready = 1;
    scans(2);
    chk("idle_none", hs_cnt, 0);
    // clean press of key 9 (row 2, column 1)
    keys = 16'h1 << 9;
    h0 = hs_cnt; c0 = v_cyc;
    scans(2);
    chk("clean_early", hs_cnt - h0, 0);
    scans(4);
    chk("clean_count", hs_cnt - h0, 1);
    chk("clean_code", last_code, 9);
    chk("clean_pulse", v_cyc - c0, 1);
    chk("clean_pressed", key_pressed, 1);
    keys = 0;
    scans(6);
    chk("clean_release", key_pressed, 0);
    chk("clean_once", hs_cnt - h0, 1);
    // reset while a key is pending
    key_ready = 0;
    keys = 16'h1 << 7;
    scans(6);
    chk("rstmid_valid_pre", key_valid, 1);
    chk("rstmid_code_pre", key_code, 7);
    @(negedge clk); #2 rst = 1;
    #1;
    chk("rstmid_col", col_n, 4'he);
    chk("rstmid_valid", key_valid, 0);
    chk("rstmid_pressed", key_pressed, 0);
    keys = 0;
    repeat (4) @(negedge clk);
    rst = 0;
    key_ready = 1;
    h0 = hs_cnt;
    scans(6);
    chk("rstmid_nokey", hs_cnt - h0, 0);
    chk("rstmid_valid_post", key_valid, 0);
    // bounce on key 3: on/off every 3 scans, never 4 stable scans
    h0 = hs_cnt;
    for (int i = 0; i < 8; i++) begin
      keys = keys ^ (16'h1 << 3);
      repeat (96) @(negedge clk);
    end
    chk("bounce_none", hs_cnt - h0, 0);
    keys = 16'h1 << 3;
    scans(2);
    chk("bounce_early", hs_cnt - h0, 0);
    scans(4);
    chk("bounce_count", hs_cnt - h0, 1);
    chk("bounce_code", last_code, 3);
    keys = 0;
    scans(6);
    // backpressure: press/release key 5 with key_ready low
    key_ready = 0;
    h0 = hs_cnt;
    keys = 16'h1 << 5;
    scans(6);
    chk("bp_valid", key_valid, 1);
    chk("bp_code", key_code, 5);
    chk("bp_pressed", key_pressed, 1);
    keys = 0;
    scans(6);
    chk("bp_rel_pressed", key_pressed, 0);
    chk("bp_rel_valid", key_valid, 1);
    chk("bp_rel_code", key_code, 5);
    key_ready = 1;
    repeat (3) @(negedge clk);
    chk("bp_consumed", key_valid, 0);
    chk("bp_count", hs_cnt - h0, 1);
    chk("bp_code_hold", key_code, 5);
    keys = 16'h1 << 6;
    scans(6);
    chk("bp_second", hs_cnt - h0, 2);
    chk("bp_second_code", last_code, 6);
    keys = 0;
    scans(6);
    // ghost: keys 0 and 5 together
    h0 = hs_cnt;
    keys = 16'h0021;
    scans(8);
    chk("ghost_none", hs_cnt - h0, 0);
    chk("ghost_pressed", key_pressed, 0);
    keys = 16'h0001;
    scans(6);
    chk("ghost_after", hs_cnt - h0, 1);
    chk("ghost_code", last_code, 0);
    keys = 0;
    scans(6);
    // long hold of key 15
    h0 = hs_cnt;
    keys = 16'h1 << 15;
    scans(40);
`ifdef KEYPAD_AUTOREPEAT_EN
    chk("hold_pulses", hs_cnt - h0, 5);
`else
    chk("hold_pulses", hs_cnt - h0, 1);
`endif
    chk("hold_code", last_code, 15);
    keys = 0;
    scans(6);
    chk("hold_release", key_pressed, 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
